sa_cache_store: RTL and testbench
=================================

Name: sa_cache_store

Overview:
- N-way tag and data storage for the set-associative cache controller.
- Holds 1024 sets × N ways.
- Each entry is one tag record (valid, dirty, 18-bit tag) and one 128-bit line.
- Reads are combinational: all N tags of the indexed set, plus the line of the selected way. The controller compares tags in the same cycle.
- Writes are synchronous and go to one selected way.

Parameters:
- N, 4, number of ways (≥1). way_sel width is max(1, clog2(N)).
- SETS, 1024, number of sets, indexed by addr[13:4]. Index width 10.
- TAGW, 18, tag width, from addr[31:14].
- LINEW, 128, line width in bits (4 × 32-bit words).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- tag_req  in  11  cache_req_type: index[9:0], we.
- tag_write  in  20  cache_tag_type {valid, dirty, tag[17:0]}, written on tag_req.we.
- tag_read  out  N×20  array of cache_tag_type: way w = tag entry [w][tag_req.index].
- data_req  in  11  cache_req_type: index[9:0], we.
- data_write  in  128  line written on data_req.we.
- data_read  out  128  line [way_sel][data_req.index].
- way_sel  in  clog2(N)  way targeted by both writes and by the data_read mux.

Behaviour:
- Reads:
  - Purely combinational; zero latency.
  - tag_read and data_read follow index and way_sel changes within the same cycle.
- Tag write: at posedge clk with tag_req.we=1 and rst=0, tag[way_sel][tag_req.index] <= tag_write. Other ways and sets are unchanged.
- Data write: at posedge clk with data_req.we=1 and rst=0, data[way_sel][data_req.index] <= data_write.
- Tag and data writes are independent. Both may occur in the same cycle at different indices.
- Read during write to the same entry: the old value is visible until the edge; the new value is visible after it. No write-through bypass.
- way_sel ≥ N (non-power-of-2 N): the write is ignored and data_read returns 0.
- Reset:
  - At posedge with rst=1, every tag entry of every way and set is cleared to 0 (valid=0, dirty=0, tag=0).
  - After reset, tag_read reads all zeros for any index.
  - Data array is not reset. data_read of a never-written line is don't-care; benches must not check it.
- rst has priority over a simultaneous we: no write occurs in a reset cycle.
- Reset mid-operation: a write asserted in the same cycle as rst is lost. The next cycle operates normally.
- No handshake: we is a single-cycle strobe, one write per edge per array.
- Tag equality, LRU/MRU policy and dirty tracking are the controller's responsibility. This block stores exactly what it is given.

Decomposition:
- Package cache_def (shared with the controller):
  - N, TAGMSB=31, TAGLSB=14
  - cache_tag_type, cache_req_type
  - cache_data_type (logic[127:0])
  - cpu/mem request and result types
- Sub-module cache_way_array:
  - One way holding SETS tag entries and SETS lines.
  - Combinational read, synchronous write enabled by its way-select decode, synchronous tag clear.
- sa_cache_store instantiates N copies in a generate loop, decodes way_sel into per-way write enables, and muxes data_read.

Test Plan:
- Reset test: assert rst for 2 cycles, then scan index 0, 512 and 1023 → every tag_read[w] = {0,0,0} for all w.
- Single-way isolation: tag write {1,0,18'h2A5} to way 2, index 10'h03F → tag_read[2]={1,0,2A5}, other ways at index 3F still 0. Repeat for a data write of 128'h0123…CDEF to way 2, index 3F → data_read matches with way_sel=2 and equals the reset/unwritten state otherwise.
- Read-during-write timing: index 5 holds line A; in one cycle write B with way_sel=1 and sample data_read → A before the edge, B after.
- Way mux: write distinct lines 128'h1, 2, 3, 4 to ways 0–3 at index 100 → stepping way_sel 0..3 combinationally yields 1, 2, 3, 4 in the same cycle.
- Reset priority: tag_req.we=1 and rst=1 in the same cycle with {1,1,18'h3FFFF} → tag reads {0,0,0} afterwards.
- Dirty update: overwrite the way-0, index-7 tag {1,0,T} with {1,1,T} → dirty=1, tag unchanged, way 1 at index 7 unaffected.

Source files
------------

// File: rtl/cache_def_pkg.sv
// Shared cache definitions used by the cache controller and its tag/data store.
// Provides the geometry constants, tag record, request record and the
// CPU/memory interface types. The tag field sits at addr[TAGMSB:TAGLSB],
// and the set index sits at addr[13:4].
package cache_def;

  localparam int N      = 4;
  localparam int SETS   = 1024;
  localparam int IDXW   = 10;
  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;
  localparam int TAGW   = TAGMSB - TAGLSB + 1;
  localparam int LINEW  = 128;

  typedef struct packed {
    logic            valid;
    logic            dirty;
    logic [TAGW-1:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [IDXW-1:0] index;
    logic            we;
  } cache_req_type;

  typedef logic [LINEW-1:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

// File: rtl/cache_way_array.sv
// One way of the set-associative store: SETS tag records plus SETS lines.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears tags only)
//   tag_index, tag_we     tag array address and write enable (already way-decoded)
//   tag_write, tag_read   tag record in / combinational tag record out
//   data_index, data_we   line array address and write enable (already way-decoded)
//   data_write, data_read line in / combinational line out
module cache_way_array
  import cache_def::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDXW-1:0]      tag_index,
  input  logic                 tag_we,
  input  cache_tag_type        tag_write,
  output cache_tag_type        tag_read,
  input  logic [IDXW-1:0]      data_index,
  input  logic                 data_we,
  input  cache_data_type       data_write,
  output cache_data_type       data_read
);

  cache_tag_type  tags  [SETS];
  cache_data_type lines [SETS];

  // Reset wipes every tag so no stale entry can look valid; it also wins
  // over a write strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) tags[i] <= '0;
    end else if (tag_we) begin
      tags[tag_index] <= tag_write;
    end
  end

  // Lines are never cleared; the valid bit in the tag guards them.
  always_ff @(posedge clk) begin
    if (!rst && data_we) lines[data_index] <= data_write;
  end

  assign tag_read  = tags[tag_index];
  assign data_read = lines[data_index];

endmodule

// File: rtl/sa_cache_store.sv
// N-way tag and data storage for the set-associative cache controller.
// Reads are combinational; writes land on the rising edge into the way
// chosen by way_sel.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears all tags)
//   tag_req     tag index and write strobe
//   tag_write   tag record stored on tag_req.we
//   tag_read    tag record of every way at tag_req.index
//   data_req    line index and write strobe
//   data_write  line stored on data_req.we
//   data_read   line of way way_sel at data_req.index (0 if way_sel >= N)
//   way_sel     way targeted by both writes and the data_read mux
module sa_cache_store
  import cache_def::*;
#(
  parameter int NW  = N,
  parameter int WSW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cache_req_type            tag_req,
  input  cache_tag_type            tag_write,
  output cache_tag_type [NW-1:0]   tag_read,
  input  cache_req_type            data_req,
  input  cache_data_type           data_write,
  output cache_data_type           data_read,
  input  logic [WSW-1:0]           way_sel
);

  cache_data_type way_lines [NW];

  for (genvar w = 0; w < NW; w++) begin : g_way
    // A way_sel past the last way matches no copy, so the write is dropped.
    logic hit;
    assign hit = (way_sel == WSW'(w));

    cache_way_array u_way (
      .clk        (clk),
      .rst        (rst),
      .tag_index  (tag_req.index),
      .tag_we     (tag_req.we && hit),
      .tag_write  (tag_write),
      .tag_read   (tag_read[w]),
      .data_index (data_req.index),
      .data_we    (data_req.we && hit),
      .data_write (data_write),
      .data_read  (way_lines[w])
    );
  end

  always_comb begin
    data_read = '0;
    for (int i = 0; i < NW; i++) begin
      if (way_sel == WSW'(i)) data_read = way_lines[i];
    end
  end

endmodule

// File: tb/tb_sa_cache_store.sv
// Directed bench for sa_cache_store with hand-computed expected values.
module tb_sa_cache_store;
  import cache_def::*;

  localparam int WSW = 2;

  logic                  clk;
  logic                  rst;
  cache_req_type         tag_req;
  cache_tag_type         tag_write;
  cache_tag_type [N-1:0] tag_read;
  cache_req_type         data_req;
  cache_data_type        data_write;
  cache_data_type        data_read;
  logic [WSW-1:0]        way_sel;

  int n_checks = 0;
  int n_fails  = 0;

  sa_cache_store dut (
    .clk        (clk),
    .rst        (rst),
    .tag_req    (tag_req),
    .tag_write  (tag_write),
    .tag_read   (tag_read),
    .data_req   (data_req),
    .data_write (data_write),
    .data_read  (data_read),
    .way_sel    (way_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [17:0] T7  = 18'h1B3C4;
  localparam logic [17:0] T7B = 18'h00F0F;
  localparam logic [127:0] LINE_A = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
  localparam logic [127:0] LINE_B = 128'hBBBB_9999_8888_7777_6666_5555_4444_BBBB;
  localparam logic [127:0] LINE_K = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  int scan_idx [3] = '{0, 512, 1023};

  initial begin
    rst        = 1'b1;
    tag_req    = '0;
    tag_write  = '0;
    data_req   = '0;
    data_write = '0;
    way_sel    = '0;

    // Reset for two cycles, then every way of sampled sets reads zero.
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tag_req.index = scan_idx[k][9:0];
      #1;
      for (int w = 0; w < N; w++)
        check($sformatf("reset_tag_i%0d_w%0d", scan_idx[k], w), 128'(tag_read[w]), 128'h0);
    end

    // Single-way isolation: tag and line written to way 2, set 3F.
    way_sel    = 2'd2;
    tag_req    = {10'h03F, 1'b1};
    tag_write  = {1'b1, 1'b0, 18'h002A5};
    data_req   = {10'h03F, 1'b1};
    data_write = LINE_K;
    tick();
    tag_req.we  = 1'b0;
    data_req.we = 1'b0;
    #1;
    check("iso_tag_w2", 128'(tag_read[2]), 128'({1'b1, 1'b0, 18'h002A5}));
    check("iso_tag_w0", 128'(tag_read[0]), 128'h0);
    check("iso_tag_w1", 128'(tag_read[1]), 128'h0);
    check("iso_tag_w3", 128'(tag_read[3]), 128'h0);
    check("iso_data_w2", data_read, LINE_K);

    // Read during write: old line until the edge, new line after it.
    way_sel    = 2'd1;
    data_req   = {10'd5, 1'b1};
    data_write = LINE_A;
    tick();
    data_write = LINE_B;
    #1;
    check("rdw_before_edge", data_read, LINE_A);
    tick();
    data_req.we = 1'b0;
    #1;
    check("rdw_after_edge", data_read, LINE_B);

    // Way mux: distinct lines per way at set 100, then step way_sel.
    for (int w = 0; w < N; w++) begin
      way_sel    = WSW'(w);
      data_req   = {10'd100, 1'b1};
      data_write = 128'(w + 1);
      tick();
    end
    data_req.we = 1'b0;
    for (int w = 0; w < N; w++) begin
      way_sel = WSW'(w);
      #1;
      check($sformatf("mux_w%0d", w), data_read, 128'(w + 1));
    end

    // Tag and data writes at different indices in one cycle.
    way_sel    = 2'd3;
    tag_req    = {10'd200, 1'b1};
    tag_write  = {1'b1, 1'b0, 18'h12345};
    data_req   = {10'd201, 1'b1};
    data_write = LINE_A;
    tick();
    tag_req.we  = 1'b0;
    data_req.we = 1'b0;
    #1;
    check("dual_tag_w3", 128'(tag_read[3]), 128'({1'b1, 1'b0, 18'h12345}));
    check("dual_data_w3", data_read, LINE_A);

    // Reset priority: write strobe coincident with rst is lost.
    way_sel   = 2'd3;
    tag_req   = {10'd9, 1'b1};
    tag_write = {1'b1, 1'b1, 18'h3FFFF};
    rst       = 1'b1;
    tick();
    rst        = 1'b0;
    tag_req.we = 1'b0;
    #1;
    check("rstpri_tag_w3", 128'(tag_read[3]), 128'h0);
    tag_req.index = 10'h03F;
    #1;
    check("rstpri_clears_3f_w2", 128'(tag_read[2]), 128'h0);
    // Next cycle after reset operates normally.
    tag_req = {10'd9, 1'b1};
    tick();
    tag_req.we = 1'b0;
    #1;
    check("post_rst_write", 128'(tag_read[3]), 128'({1'b1, 1'b1, 18'h3FFFF}));

    // Dirty update on way 0, set 7; way 1 holds a different tag.
    way_sel   = 2'd0;
    tag_req   = {10'd7, 1'b1};
    tag_write = {1'b1, 1'b0, T7};
    tick();
    way_sel   = 2'd1;
    tag_write = {1'b1, 1'b0, T7B};
    tick();
    way_sel   = 2'd0;
    tag_write = {1'b1, 1'b1, T7};
    tick();
    tag_req.we = 1'b0;
    #1;
    check("dirty_w0", 128'(tag_read[0]), 128'({1'b1, 1'b1, T7}));
    check("dirty_w1_kept", 128'(tag_read[1]), 128'({1'b1, 1'b0, T7B}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
